// File: rtl/ddr_512b_adc_gen.sv
// ddr_512b_adc_gen: 512-bit test-pattern source for the ADC/DDR datapath.
// Each beat carries 32 x 16-bit lanes, lane k = seed + (k mod 4). The seed
// steps by 4 per accepted beat so the downstream checker sees a continuous
// count. Runs are started, sized, paced, stopped and error-injected from
// the config register bank.
`timescale 1ns/1ps

module ddr_512b_adc_gen #(
  parameter int DATA_WD = 512,
  parameter int CNT_WD  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_rst,
  input  logic               cfg_start,
  input  logic               cfg_stop,
  input  logic [CNT_WD-1:0]  cfg_beat_num,
  input  logic [7:0]         cfg_gap,
  input  logic               cfg_err_inj,
  input  logic               adc_rdy,
  output logic               adc_vld,
  output logic [DATA_WD-1:0] adc_data,
  output logic               busy,
  output logic               done,
  output logic [CNT_WD-1:0]  tx_cnt
);

  localparam int LANES = DATA_WD / 16;
  localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state;
  logic [15:0]       seed;
  logic [CNT_WD-1:0] beat_cnt;
  logic [CNT_WD-1:0] beat_num_q;
  logic [7:0]        gap_q;
  logic [7:0]        gap_cnt;
  logic              stop_pend;
  logic              err_pend;
  logic              cur_bad;     // the beat currently presented is corrupted

  logic              accept;
  logic              stop_now;
  logic              last_beat;
  logic [15:0]       seed_nx;
  logic              err_nx;

  // Build one beat: lanes repeat seed, seed+1, seed+2, seed+3 (mod 2^16);
  // a corrupted beat has bit 0 of lane 0 inverted.
  function automatic logic [DATA_WD-1:0] make_beat(input logic [15:0] s,
                                                   input logic        bad);
    logic [DATA_WD-1:0] b;
    b = '0;
    for (int k = 0; k < LANES; k++) begin
      b[k*16 +: 16] = s + 16'(k % 4);
    end
    b[0] = b[0] ^ bad;
    return b;
  endfunction

  assign accept    = adc_vld & adc_rdy;
  assign stop_now  = stop_pend | cfg_stop;
  assign last_beat = (beat_num_q != '0) && ((beat_cnt + CNT_ONE) == beat_num_q);
  assign seed_nx   = accept ? seed + 16'd4 : seed;

  // Error flag after this cycle: a pulse arms it, accepting the corrupted beat
  // disarms it, and a pulse landing on that same acceptance is absorbed.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    err_nx = err_pend | cfg_err_inj;
    if (accept && cur_bad) begin
      err_nx = 1'b0;
    end
  end

  // Run control FSM with registered handshake, payload and status outputs.
  always_ff @(posedge clk) begin
    if (rst || cfg_rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state      <= S_IDLE;
      seed       <= '0;
      beat_cnt   <= '0;
      beat_num_q <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
      stop_pend  <= 1'b0;
      err_pend   <= 1'b0;
      cur_bad    <= 1'b0;
      adc_vld    <= 1'b0;
      adc_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tx_cnt     <= '0;
    end else begin
      err_pend <= err_nx;
      done     <= 1'b0;
      if (accept) begin
        seed     <= seed_nx;
        tx_cnt   <= tx_cnt + CNT_ONE;
        beat_cnt <= beat_cnt + CNT_ONE;
      end
      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (cfg_start) begin
            state      <= S_SEND;
            busy       <= 1'b1;
            adc_vld    <= 1'b1;
            adc_data   <= make_beat(seed_nx, err_nx);
            cur_bad    <= err_nx;
            beat_cnt   <= '0;
            beat_num_q <= cfg_beat_num;
            gap_q      <= cfg_gap;
          end
        end
        S_SEND: begin
          if (cfg_stop) begin
            stop_pend <= 1'b1;
          end
          // A presented beat is never withdrawn: exits wait for acceptance.
          if (accept) begin
            if (stop_now || last_beat) begin
              state     <= S_DONE;
              adc_vld   <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
            end else if (gap_q != 8'd0) begin
              state   <= S_GAP;
              adc_vld <= 1'b0;
              gap_cnt <= gap_q;
            end else begin
              adc_data <= make_beat(seed_nx, err_nx);
              cur_bad  <= err_nx;
            end
          end
        end
        S_GAP: begin
          if (cfg_stop) begin
            stop_pend <= 1'b1;
          end
          if (stop_now) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            stop_pend <= 1'b0;
          end else if (gap_cnt <= 8'd1) begin
            state    <= S_SEND;
            adc_vld  <= 1'b1;
            adc_data <= make_beat(seed_nx, err_nx);
            cur_bad  <= err_nx;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          stop_pend <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_512b_adc_gen.sv
// tb_ddr_512b_adc_gen: directed bench for the 512-bit pattern source with a
// loopback checker model (expected seed, success/error counts, beat count).
`timescale 1ns/1ps

module tb_ddr_512b_adc_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_rst;
  logic         cfg_start;
  logic         cfg_stop;
  logic [31:0]  cfg_beat_num;
  logic [7:0]   cfg_gap;
  logic         cfg_err_inj;
  logic         adc_rdy;
  logic         adc_vld;
  logic [511:0] adc_data;
  logic         busy;
  logic         done;
  logic [31:0]  tx_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Loopback checker model.
  logic [15:0]  m_seed;
  int           m_suc;
  int           m_err;
  int           m_tx;
  bit           stalled;
  logic [511:0] held;
  logic [15:0]  lane0_q[$];
  logic [511:0] data_q[$];

  ddr_512b_adc_gen #(.DATA_WD(512), .CNT_WD(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_rst      (cfg_rst),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_beat_num (cfg_beat_num),
    .cfg_gap      (cfg_gap),
    .cfg_err_inj  (cfg_err_inj),
    .adc_rdy      (adc_rdy),
    .adc_vld      (adc_vld),
    .adc_data     (adc_data),
    .busy         (busy),
    .done         (done),
    .tx_cnt       (tx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beat: eight copies of {s+3, s+2, s+1, s}, lane 0 in the low bits.
  function automatic logic [511:0] exp_beat(input logic [15:0] s);
    logic [63:0] grp;
    grp = {s + 16'd3, s + 16'd2, s + 16'd1, s};
    return {8{grp}};
  endfunction

  // Checker model: observes each handshake a little after the inputs settle.
  always begin
    @(negedge clk);
    #2;
    if (rst || cfg_rst) begin
      m_seed  = 16'h0000;
      m_suc   = 0;
      m_err   = 0;
      m_tx    = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_vld", adc_vld, 1);
        check("stall_data", adc_data, held);
      end
      if (adc_vld && adc_rdy) begin
        if (adc_data == exp_beat(m_seed)) m_suc++;
        else m_err++;
        m_seed = m_seed + 16'd4;
        m_tx++;
        lane0_q.push_back(adc_data[15:0]);
        data_q.push_back(adc_data);
      end
      stalled = adc_vld && !adc_rdy;
      held    = adc_data;
    end
  end

  task automatic clear_queues();
    lane0_q.delete();
    data_q.delete();
  endtask

  task automatic soft_clear();
    @(negedge clk);
    cfg_rst = 1'b1;
    @(negedge clk);
    cfg_rst = 1'b0;
  endtask

  // Start a run and service it until done (or the cycle budget expires),
  // checking inter-beat idle spacing and the one-cycle done pulse.
  task automatic drive_run(input logic [31:0] n, input logic [7:0] g, input bit rnd,
                           input int inj_a, input int inj_b, input int max_cyc,
                           output int cyc);
    int idle;
    bit after_acc;
    @(negedge clk);
    cfg_beat_num = n;
    cfg_gap      = g;
    cfg_start    = 1'b1;
    adc_rdy      = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0;
    check("vld_after_start", adc_vld, 1);
    check("busy_after_start", busy, 1);
    cyc = 0;
    idle = 0;
    after_acc = 1'b0;
    while (!done && cyc < max_cyc) begin
      if (after_acc && adc_vld) begin
        check("gap_len", idle, g);
        after_acc = 1'b0;
      end else if (after_acc) begin
        idle++;
      end
      adc_rdy     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_err_inj = (cyc == inj_a) || (cyc == inj_b);
      if (adc_vld && adc_rdy) begin
        after_acc = 1'b1;
        idle = 0;
      end
      @(negedge clk);
      cfg_err_inj = 1'b0;
      cyc++;
    end
    check("done_seen", done, 1);
    check("busy_at_done", busy, 0);
    check("vld_at_done", adc_vld, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; cfg_rst = 1'b0; cfg_start = 1'b0; cfg_stop = 1'b0;
    cfg_beat_num = '0; cfg_gap = '0; cfg_err_inj = 1'b0; adc_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_vld", adc_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx", tx_cnt, 0);
    check("rst_data", adc_data, 0);
    rst = 1'b0;

    // 1: four back-to-back beats from a cleared seed.
    soft_clear();
    clear_queues();
    drive_run(32'd4, 8'd0, 1'b0, -1, -1, 50, cyc);
    check("t1_latency", cyc, 4);
    check("t1_count", lane0_q.size(), 4);
    check("t1_l0_0", lane0_q[0], 16'h0000);
    check("t1_l0_3", lane0_q[3], 16'h000C);
    check("t1_beat1", data_q[1], {8{64'h0007_0006_0005_0004}});
    check("t1_tx", tx_cnt, 32'd4);
    check("t1_suc", m_suc, 4);
    check("t1_err", m_err, 0);

    // 2: gap of 2 with a randomly stalling sink.
    soft_clear();
    clear_queues();
    drive_run(32'd3, 8'd2, 1'b1, -1, -1, 300, cyc);
    check("t2_count", lane0_q.size(), 3);
    check("t2_l0_0", lane0_q[0], 16'h0000);
    check("t2_l0_1", lane0_q[1], 16'h0004);
    check("t2_l0_2", lane0_q[2], 16'h0008);
    check("t2_tx", tx_cnt, 32'd3);
    check("t2_err", m_err, 0);

    // 3: continuous run (seed carries over), stop requested during a stall.
    clear_queues();
    @(negedge clk);
    cfg_beat_num = 32'd0; cfg_gap = 8'd0; adc_rdy = 1'b1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    adc_rdy = 1'b0; cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    check("t3_stall_vld", adc_vld, 1);
    check("t3_stall_l0", adc_data[15:0], 16'h0014);
    @(negedge clk);
    check("t3_not_withdrawn", adc_vld, 1);
    adc_rdy = 1'b1;
    @(negedge clk);
    check("t3_done", done, 1);
    check("t3_busy", busy, 0);
    check("t3_vld", adc_vld, 0);
    @(negedge clk);
    check("t3_done_pulse", done, 0);
    check("t3_no_more_vld", adc_vld, 0);
    check("t3_count", lane0_q.size(), 3);
    check("t3_first_l0", lane0_q[0], 16'h000C);
    check("t3_tx", tx_cnt, 32'd6);
    check("t3_err", m_err, 0);

    // 4: two error pulses in a 10-beat run corrupt exactly one beat.
    soft_clear();
    clear_queues();
    drive_run(32'd10, 8'd0, 1'b0, 2, 3, 50, cyc);
    check("t4_suc", m_suc, 9);
    check("t4_err", m_err, 1);
    check("t4_bad_l0", lane0_q[3], 16'h000D);
    check("t4_next_l0", lane0_q[4], 16'h0010);
    check("t4_tx", tx_cnt, 32'd10);

    // 5: preload the seed to 0xFFF8, then cross the 16-bit wrap.
    soft_clear();
    drive_run(32'd16382, 8'd0, 1'b0, -1, -1, 17000, cyc);
    clear_queues();
    drive_run(32'd3, 8'd0, 1'b0, -1, -1, 50, cyc);
    check("t5_l0_0", lane0_q[0], 16'hFFF8);
    check("t5_l0_1", lane0_q[1], 16'hFFFC);
    check("t5_l0_2", lane0_q[2], 16'h0000);
    check("t5_wrap_beat", data_q[1], {8{64'hFFFF_FFFE_FFFD_FFFC}});
    check("t5_err", m_err, 0);
    check("t5_tx", tx_cnt, 32'd16385);

    // 6: soft clear in the middle of a run with a beat presented.
    @(negedge clk);
    cfg_beat_num = 32'd0; cfg_gap = 8'd0; adc_rdy = 1'b1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_pre_vld", adc_vld, 1);
    cfg_rst = 1'b1;
    @(negedge clk);
    cfg_rst = 1'b0;
    check("t6_vld", adc_vld, 0);
    check("t6_busy", busy, 0);
    check("t6_tx", tx_cnt, 32'd0);
    check("t6_data", adc_data, 0);
    clear_queues();
    drive_run(32'd2, 8'd0, 1'b0, -1, -1, 50, cyc);
    check("t6_l0_0", lane0_q[0], 16'h0000);
    check("t6_l0_1", lane0_q[1], 16'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
